proc_status_reg: RTL

Processor status register (P) for the 6502 core: NV-BDIZC flags. Sits on both sides of the ALU: supplies `alu_carry` and `alu_BCD` to the ALU inputs, and captures the ALU's `alu_flags` output under per-flag write enables. Also handles explicit flag opcodes (CLC/SEC/CLI/SEI/CLD/SED/CLV), N/Z update from load data, stack pull (PLP/RTI), stack push image (PHP/BRK/IRQ), and the one-instruction-delayed IRQ mask the sequencer uses for interrupt polling.

---
 rtl/proc_status_reg.sv | 97 +++++++++
 1 files changed

// File: rtl/proc_status_reg.sv
// rtl/proc_status_reg.sv - 6502 processor status register (NV-BDIZC) with delayed IRQ mask
module proc_status_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_flag_we,
    input  logic [2:0] flag_op,
    input  logic       nz_load,
    input  logic [7:0] nz_data,
    input  logic       pull_we,
    input  logic [7:0] pull_data,
    input  logic       push_brk,
    input  logic       instr_done,
    output logic [7:0] status_p,
    output logic [7:0] push_data,
    output logic       alu_carry,
    output logic       alu_BCD,
    output logic       irq_mask
);

    localparam logic [7:0] RESET_P = 8'h24;

    localparam logic [2:0] OP_CLC = 3'b001;
    localparam logic [2:0] OP_SEC = 3'b010;
    localparam logic [2:0] OP_CLI = 3'b011;
    localparam logic [2:0] OP_SEI = 3'b100;
    localparam logic [2:0] OP_CLD = 3'b101;
    localparam logic [2:0] OP_SED = 3'b110;
    localparam logic [2:0] OP_CLV = 3'b111;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_mask_q;

    // Each flag resolves its own priority chain; D and I are never ALU-owned.
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;

        if (pull_we)             n_d = pull_data[7];
        else if (alu_flag_we[7]) n_d = alu_flags[7];
        else if (nz_load)        n_d = nz_data[7];

        if (pull_we)             v_d = pull_data[6];
        else if (flag_op == OP_CLV) v_d = 1'b0;
        else if (alu_flag_we[6]) v_d = alu_flags[6];

        if (pull_we)             d_d = pull_data[3];
        else if (flag_op == OP_CLD) d_d = 1'b0;
        else if (flag_op == OP_SED) d_d = 1'b1;

        if (pull_we)             i_d = pull_data[2];
        else if (flag_op == OP_CLI) i_d = 1'b0;
        else if (flag_op == OP_SEI) i_d = 1'b1;

        if (pull_we)             z_d = pull_data[1];
        else if (alu_flag_we[1]) z_d = alu_flags[1];
        else if (nz_load)        z_d = (nz_data == 8'h00);

        if (pull_we)             c_d = pull_data[0];
        else if (flag_op == OP_CLC) c_d = 1'b0;
        else if (flag_op == OP_SEC) c_d = 1'b1;
        else if (alu_flag_we[0]) c_d = alu_flags[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= RESET_P[7];
            v_q        <= RESET_P[6];
            d_q        <= RESET_P[3];
            i_q        <= RESET_P[2];
            z_q        <= RESET_P[1];
            c_q        <= RESET_P[0];
            irq_mask_q <= 1'b1;
        end else begin
            n_q <= n_d;
            v_q <= v_d;
            d_q <= d_d;
            i_q <= i_d;
            z_q <= z_d;
            c_q <= c_d;
            // Sampling next-state I makes an I write sharing the boundary cycle count.
            if (instr_done) irq_mask_q <= i_d;
        end
    end

    assign status_p  = {n_q, v_q, 1'b1, 1'b0,     d_q, i_q, z_q, c_q};
    assign push_data = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
    assign alu_carry = c_q;
    assign alu_BCD   = d_q;
    assign irq_mask  = irq_mask_q;

endmodule
